conv_layer_scheduler: RTL and testbench
=======================================

// Module: conv_layer_scheduler
// PURPOSE
// - Ping-pong scheduler for the two intermediate feature-map banks between conv layer 1 and conv layer 2.
// - Gates upstream pixel acceptance and tracks bank fill/drain state.
// - Holds layer 2 in reset between images; launches a layer-2 pass when a bank fills.
// - Lets layer 1 fill image k+1 while layer 2 consumes image k.
// PARAMETERS
// - ImageWidth       8    layer-1 input width; one frame = ImageWidth*ImageWidth accepted pixels
// - L2ResetCycles    2    minimum cycles l2_rst stays high before each layer-2 pass (>=1)
// - FrameCountWidth  16   width of frame counters
// - WatchdogCycles   4096 max cycles in R_RUN (only with SCHED_WATCHDOG_EN)
// PORTS
// - clk              in   1   clock, rising edge
// - rst              in   1   asynchronous active-high reset
// - in_valid         in   1   upstream pixel valid
// - in_ready         out  1   pixel accepted when in_valid && in_ready
// - mem_image_done   in   1   1-cycle pulse: wr_bank holds a complete pooled layer-1 image
// - l2_pooling_done  in   1   1-cycle pulse: layer 2 finished the current bank
// - wr_bank          out  1   bank layer 1 writes
// - rd_bank          out  1   bank layer 2 reads
// - bank_full        out  2   per-bank full flags
// - l2_rst           out  1   active-high reset to layer 2 (to the active-low port via inverter)
// - rd_start         out  1   1-cycle pulse on R_RUN entry
// - rd_en            out  1   high throughout R_RUN; enables bank read-out
// - frames_in        out  FW  images written to banks, wraps
// - frames_out       out  FW  images completed by layer 2, wraps
// - busy             out  1   any bank full, write FSM not in W_FILL with count 0, or read FSM not R_IDLE
// - err_protocol     out  1   sticky protocol-violation flag
// - err_timeout      out  1   sticky watchdog flag
// BEHAVIOUR
// - Reset values (async): wr_bank=0, rd_bank=0, bank_full=00, in_ready=0, l2_rst=1,
//   rd_start=0, rd_en=0, counters=0, errs=0, pixel count=0, W=W_FILL, R=R_IDLE.
// - All outputs registered.
// - Write FSM:
//   - W_FILL: in_ready=!bank_full[wr_bank]. Each accept increments pixel count.
//     Accepting pixel ImageWidth^2-1 clears count; in_ready=0 from the next cycle; go to W_DRAIN.
//   - W_DRAIN: in_ready=0. On mem_image_done: bank_full[wr_bank]<=1, wr_bank toggles, frames_in++,
//     back to W_FILL. Next cycle in_ready=!bank_full[new wr_bank], so it stalls while both banks are full.
// - Read FSM:
//   - R_IDLE: l2_rst=1. If bank_full[rd_bank], go to R_RESET.
//   - R_RESET: l2_rst=1 for exactly L2ResetCycles cycles, then R_RUN.
//   - R_RUN: l2_rst=0, rd_en=1, rd_start=1 on the first cycle only.
//     On l2_pooling_done: bank_full[rd_bank]<=0, rd_bank toggles, frames_out++, go to R_IDLE (l2_rst=1 next cycle).
// - Latency: mem_image_done at edge T gives bank_full set at T. R_IDLE sees it at T+1 and enters R_RESET.
//   rd_start occurs at T+1+L2ResetCycles.
// - Simultaneous set and clear of bank_full in one cycle: both take effect.
//   They always target different banks by construction.
// - Both banks full: input stalls. When one drains, in_ready rises the cycle after bank_full clears.
// - mem_image_done in W_FILL: ignored, err_protocol<=1.
// - l2_pooling_done outside R_RUN: ignored, err_protocol<=1.
// - in_valid while in_ready=0: no effect.
// - rst mid-operation: everything returns to reset values immediately; in-flight images are discarded.
// - Counters wrap modulo 2^FrameCountWidth.
// CONFIGURATION
// - SCHED_WATCHDOG_EN defined:
//   - Cycle counter clears on R_RUN entry and increments each R_RUN cycle.
//   - Reaching WatchdogCycles without l2_pooling_done: err_timeout<=1, bank_full[rd_bank]<=0,
//     rd_bank toggles, frames_out unchanged, go to R_IDLE (l2_rst reasserted).
// - SCHED_WATCHDOG_EN undefined: no counter; err_timeout tied 0; R_RUN waits indefinitely.
// TESTING
// - Reset, then 64 pixels with in_valid=1 -> in_ready=1 for 64 accepts, 0 from cycle 65.
//   Pulse mem_image_done -> bank_full=01, wr_bank=1, frames_in=1, in_ready=1 next cycle.
// - With L2ResetCycles=2: mem_image_done at T -> l2_rst high T+1..T+2, rd_start at T+3.
//   l2_pooling_done -> bank_full[0]=0, rd_bank=1, frames_out=1, l2_rst=1.
// - Fill two images with layer 2 stalled -> bank_full=11, in_ready=0 after the second drain.
//   l2_pooling_done -> bank_full=10, in_ready=1 next cycle.
// - Pulse mem_image_done and l2_pooling_done on the same cycle -> fill and drain both applied; no error.
// - mem_image_done after 10 of 64 pixels -> err_protocol=1, bank_full unchanged.
//   Assert rst mid-frame -> all outputs at reset values the same cycle.
// - With SCHED_WATCHDOG_EN and WatchdogCycles=100, no l2_pooling_done -> err_timeout=1 after 100 R_RUN cycles,
//   bank released, frames_out=0.
//   Without the macro -> err_timeout stays 0 and R_RUN holds.

Source files
------------

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: ping-pong bank scheduler between conv layer 1 (writer) and conv layer 2 (reader).
// Optional watchdog on layer-2 passes is enabled with SCHED_WATCHDOG_EN.
module conv_layer_scheduler #(
  parameter int ImageWidth      = 8,
  parameter int L2ResetCycles   = 2,
  parameter int FrameCountWidth = 16
`ifdef SCHED_WATCHDOG_EN
  , parameter int WatchdogCycles = 4096
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mem_image_done,
  input  logic                       l2_pooling_done,
  output logic                       wr_bank,
  output logic                       rd_bank,
  output logic [1:0]                 bank_full,
  output logic                       l2_rst,
  output logic                       rd_start,
  output logic                       rd_en,
  output logic [FrameCountWidth-1:0] frames_in,
  output logic [FrameCountWidth-1:0] frames_out,
  output logic                       busy,
  output logic                       err_protocol,
  output logic                       err_timeout
);
  localparam int Pixels = ImageWidth * ImageWidth;
  localparam int PW = $clog2(Pixels + 1);
  localparam int RW = $clog2(L2ResetCycles + 1);
  typedef enum logic {W_FILL, W_DRAIN} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RESET, R_RUN} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [PW-1:0] pix;
  logic [RW-1:0] rcnt;
`ifdef SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WatchdogCycles + 1);
  logic [WW-1:0] wcnt;
`else
  assign err_timeout = 1'b0;
`endif
  assign busy = (|bank_full) || w_state != W_FILL || pix != '0 || r_state != R_IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state      <= W_FILL;
      r_state      <= R_IDLE;
      pix          <= '0;
      rcnt         <= '0;
      in_ready     <= 1'b0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      bank_full    <= 2'b00;
      l2_rst       <= 1'b1;
      rd_start     <= 1'b0;
      rd_en        <= 1'b0;
      frames_in    <= '0;
      frames_out   <= '0;
      err_protocol <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      wcnt         <= '0;
      err_timeout  <= 1'b0;
`endif
    end else begin
      if (w_state == W_FILL) begin
        if (mem_image_done) err_protocol <= 1'b1;
        if (in_valid && in_ready && pix == PW'(Pixels - 1)) begin
          pix      <= '0;
          in_ready <= 1'b0;
          w_state  <= W_DRAIN;
        end else begin
          if (in_valid && in_ready) pix <= pix + 1'b1;
          in_ready <= !bank_full[wr_bank];
        end
      end else if (mem_image_done) begin
        bank_full[wr_bank] <= 1'b1;
        wr_bank            <= !wr_bank;
        frames_in          <= frames_in + 1'b1;
        w_state            <= W_FILL;
      end
      // read side clears only bank_full[rd_bank], never the bank being set above
      rd_start <= 1'b0;
      if (l2_pooling_done && r_state != R_RUN) err_protocol <= 1'b1;
      case (r_state)
        R_IDLE: if (bank_full[rd_bank]) begin
          r_state <= R_RESET;
          rcnt    <= '0;
        end
        R_RESET: if (rcnt == RW'(L2ResetCycles - 1)) begin
          r_state  <= R_RUN;
          l2_rst   <= 1'b0;
          rd_en    <= 1'b1;
          rd_start <= 1'b1;
`ifdef SCHED_WATCHDOG_EN
          wcnt     <= '0;
`endif
        end else rcnt <= rcnt + 1'b1;
        R_RUN: if (l2_pooling_done) begin
          bank_full[rd_bank] <= 1'b0;
          rd_bank            <= !rd_bank;
          frames_out         <= frames_out + 1'b1;
          r_state            <= R_IDLE;
          l2_rst             <= 1'b1;
          rd_en              <= 1'b0;
        end
`ifdef SCHED_WATCHDOG_EN
        else if (wcnt == WW'(WatchdogCycles - 1)) begin
          err_timeout        <= 1'b1;
          bank_full[rd_bank] <= 1'b0;
          rd_bank            <= !rd_bank;
          r_state            <= R_IDLE;
          l2_rst             <= 1'b1;
          rd_en              <= 1'b0;
        end else wcnt <= wcnt + 1'b1;
`endif
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb_conv_layer_scheduler: directed bench for conv_layer_scheduler (8x8 frames, 2 reset cycles).
module tb_conv_layer_scheduler;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mem_image_done = 1'b0, l2_pooling_done = 1'b0;
  logic in_ready, wr_bank, rd_bank, l2_rst, rd_start, rd_en, busy, err_protocol, err_timeout;
  logic [1:0] bank_full;
  logic [15:0] frames_in, frames_out;
  logic [10:0] flags;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  conv_layer_scheduler #(.ImageWidth(8), .L2ResetCycles(2), .FrameCountWidth(16)
`ifdef SCHED_WATCHDOG_EN
    , .WatchdogCycles(100)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_image_done(mem_image_done), .l2_pooling_done(l2_pooling_done),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .bank_full(bank_full), .l2_rst(l2_rst),
    .rd_start(rd_start), .rd_en(rd_en), .frames_in(frames_in), .frames_out(frames_out),
    .busy(busy), .err_protocol(err_protocol), .err_timeout(err_timeout)
  );
  // {in_ready, wr_bank, rd_bank, bank_full[1:0], l2_rst, rd_start, rd_en, busy, err_protocol, err_timeout}
  assign flags = {in_ready, wr_bank, rd_bank, bank_full, l2_rst, rd_start, rd_en, busy, err_protocol, err_timeout};
  task automatic feed(input int n, output int acc);
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && acc < n; i++) begin
      if (in_ready) acc++;
      @(negedge clk);
    end
  endtask
  task automatic pulse(input logic m, input logic l);
    mem_image_done = m;
    l2_pooling_done = l;
    @(negedge clk);
    mem_image_done = 1'b0;
    l2_pooling_done = 1'b0;
  endtask
  task automatic wait_run(input string tag);
    for (int i = 0; i < 20 && rd_en !== 1'b1; i++) @(negedge clk);
    checks++;
    if (rd_en !== 1'b1) begin errors++; $display("FAIL %s rd_en got %b want 1", tag, rd_en); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (flags !== 11'b000_00_1_0_0_0_0_0) begin errors++; $display("FAIL reset_flags got %b want 00000100000", flags); end
    checks++;
    if ({frames_in, frames_out} !== 32'h0) begin errors++; $display("FAIL reset_counters got %h want 0", {frames_in, frames_out}); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask
  task automatic test_first_frame();
    int acc;
    feed(64, acc);
    checks++;
    if (acc !== 64 || in_ready !== 1'b0) begin errors++; $display("FAIL frame_accepts got %0d/%b want 64/0", acc, in_ready); end
    @(negedge clk);
    checks++;
    if ({in_ready, busy, frames_in} !== {1'b0, 1'b1, 16'd0}) begin errors++; $display("FAIL drain_hold got %b%b/%0d want 01/0", in_ready, busy, frames_in); end
    in_valid = 1'b0;
    pulse(1'b1, 1'b0);
    checks++;
    if ({bank_full, wr_bank, in_ready, l2_rst, frames_in} !== {2'b01, 1'b1, 1'b0, 1'b1, 16'd1}) begin
      errors++; $display("FAIL image_done got %b %b %b %b %0d want 01 1 0 1 1", bank_full, wr_bank, in_ready, l2_rst, frames_in);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, l2_rst, rd_start} !== 3'b110) begin errors++; $display("FAIL t1 got %b want 110", {in_ready, l2_rst, rd_start}); end
    @(negedge clk);
    checks++;
    if ({l2_rst, rd_start, rd_en} !== 3'b100) begin errors++; $display("FAIL t2 got %b want 100", {l2_rst, rd_start, rd_en}); end
    @(negedge clk);
    checks++;
    if ({l2_rst, rd_start, rd_en} !== 3'b011) begin errors++; $display("FAIL t3_start got %b want 011", {l2_rst, rd_start, rd_en}); end
    @(negedge clk);
    checks++;
    if ({l2_rst, rd_start, rd_en} !== 3'b001) begin errors++; $display("FAIL t4_run got %b want 001", {l2_rst, rd_start, rd_en}); end
  endtask
  task automatic test_drain();
    pulse(1'b0, 1'b1);
    checks++;
    if (flags !== 11'b111_00_1_0_0_0_0_0) begin errors++; $display("FAIL drain_flags got %b want 11100100000", flags); end
    checks++;
    if (frames_out !== 16'd1) begin errors++; $display("FAIL drain_frames_out got %0d want 1", frames_out); end
  endtask
  task automatic test_both_full();
    int acc;
    feed(64, acc);
    in_valid = 1'b0;
    pulse(1'b1, 1'b0);
    checks++;
    if ({bank_full, wr_bank} !== 3'b100) begin errors++; $display("FAIL bf_first got %b want 100", {bank_full, wr_bank}); end
    feed(64, acc);
    in_valid = 1'b0;
    pulse(1'b1, 1'b0);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bank_full, wr_bank, in_ready, frames_in} !== {2'b11, 1'b1, 1'b0, 16'd3}) begin
      errors++; $display("FAIL both_full got %b %b %b %0d want 11 1 0 3", bank_full, wr_bank, in_ready, frames_in);
    end
    in_valid = 1'b0;
    pulse(1'b0, 1'b1);
    checks++;
    if ({bank_full, rd_bank, in_ready, frames_out} !== {2'b01, 1'b0, 1'b0, 16'd2}) begin
      errors++; $display("FAIL release got %b %b %b %0d want 01 0 0 2", bank_full, rd_bank, in_ready, frames_out);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", in_ready); end
  endtask
  task automatic test_simultaneous();
    int acc;
    feed(64, acc);
    in_valid = 1'b0;
    wait_run("simul_run");
    pulse(1'b1, 1'b1);
    checks++;
    if ({bank_full, wr_bank, rd_bank, err_protocol} !== 5'b10010) begin
      errors++; $display("FAIL simul_flags got %b want 10010", {bank_full, wr_bank, rd_bank, err_protocol});
    end
    checks++;
    if ({frames_in, frames_out} !== {16'd4, 16'd3}) begin errors++; $display("FAIL simul_counts got %0d/%0d want 4/3", frames_in, frames_out); end
    wait_run("simul_rerun");
    pulse(1'b0, 1'b1);
    checks++;
    if ({bank_full, rd_bank, frames_out} !== {2'b00, 1'b0, 16'd4}) begin
      errors++; $display("FAIL simul_drain got %b %b %0d want 00 0 4", bank_full, rd_bank, frames_out);
    end
  endtask
  task automatic test_protocol();
    int acc;
    feed(10, acc);
    in_valid = 1'b0;
    checks++;
    if ({acc, busy} !== {32'd10, 1'b1}) begin errors++; $display("FAIL partial got %0d/%b want 10/1", acc, busy); end
    pulse(1'b1, 1'b0);
    checks++;
    if ({err_protocol, bank_full, wr_bank, frames_in} !== {1'b1, 2'b00, 1'b0, 16'd4}) begin
      errors++; $display("FAIL early_done got %b %b %b %0d want 1 00 0 4", err_protocol, bank_full, wr_bank, frames_in);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (flags !== 11'b000_00_1_0_0_0_0_0 || {frames_in, frames_out} !== 32'h0) begin
      errors++; $display("FAIL async_reset got %b %h want 00000100000 0", flags, {frames_in, frames_out});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse(1'b0, 1'b1);
    checks++;
    if ({err_protocol, rd_bank, l2_rst, frames_out} !== {1'b1, 1'b0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL idle_done got %b %b %b %0d want 1 0 1 0", err_protocol, rd_bank, l2_rst, frames_out);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_watchdog();
    int acc;
    feed(64, acc);
    in_valid = 1'b0;
    pulse(1'b1, 1'b0);
    wait_run("wd_run");
`ifdef SCHED_WATCHDOG_EN
    repeat (99) @(negedge clk);
    checks++;
    if ({rd_en, err_timeout} !== 2'b10) begin errors++; $display("FAIL wd_pre got %b want 10", {rd_en, err_timeout}); end
    @(negedge clk);
    checks++;
    if ({err_timeout, rd_en, l2_rst, bank_full, rd_bank, frames_out} !== {1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 16'd0}) begin
      errors++; $display("FAIL wd_fire got %b %b %b %b %b %0d want 1 0 1 00 1 0", err_timeout, rd_en, l2_rst, bank_full, rd_bank, frames_out);
    end
`else
    repeat (150) @(negedge clk);
    checks++;
    if ({rd_en, l2_rst, err_timeout, bank_full} !== 5'b10001) begin
      errors++; $display("FAIL no_wd_hold got %b want 10001", {rd_en, l2_rst, err_timeout, bank_full});
    end
    pulse(1'b0, 1'b1);
    checks++;
    if ({frames_out, bank_full} !== {16'd1, 2'b00}) begin errors++; $display("FAIL no_wd_drain got %0d %b want 1 00", frames_out, bank_full); end
`endif
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_drain();
    test_both_full();
    test_simultaneous();
    test_protocol();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
